// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - button conditioner signal bundle
interface btn_debounce_if;
    logic       btn_raw;
    logic       clr_count;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    modport master (
        output btn_raw,
        output clr_count,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );

    modport slave (
        input  btn_raw,
        input  clr_count,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output press_count
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debounce FSM, edge strobes and press counter
module btn_debounce #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    btn_debounce_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] STABLE_CNT = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_WAIT_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_WAIT_L = 2'd3
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 level_q;
    logic                 press_q;
    logic                 release_q;
    logic [7:0]           count_q;
    logic [7:0]           count_inc_d;

    assign count_inc_d = count_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (bus.clr_count) begin
                count_q <= 8'd0;
            end
            case (state_q)
                ST_LOW: begin
                    if (sync2_q) begin
                        state_q <= ST_WAIT_H;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ST_WAIT_H: begin
                    if (!sync2_q) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_CNT) begin
                        state_q <= ST_HIGH;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        cnt_q   <= '0;
                        // A clear landing on a commit must not swallow that press.
                        count_q <= bus.clr_count ? 8'd1 : count_inc_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= ST_WAIT_L;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ST_WAIT_L: begin
                    if (sync2_q) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_CNT) begin
                        state_q   <= ST_LOW;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.press_count   = count_q;
endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - randomized and directed bench for btn_debounce against a sample-history model
module tb_btn_debounce;
    localparam int S = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   model_on = 1'b0;

    btn_debounce_if bus_if ();

    btn_debounce #(.STABLE_CYCLES(S), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a new level is accepted once the last S+1 synchronised samples
    // all differ from the current level; synchronised sample = raw two edges ago.
    bit       r1 = 0, r2 = 0;
    bit       hist[$];
    bit       m_level = 0, m_press = 0, m_rel = 0;
    bit [7:0] m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        bit s;
        bit all_diff;
        if (!rst_n) begin
            r1 = 0; r2 = 0; hist.delete();
            m_level = 0; m_press = 0; m_rel = 0; m_count = 0;
        end else begin
            s = r2; r2 = r1; r1 = bus_if.btn_raw;
            hist.push_back(s);
            if (hist.size() > S + 1) void'(hist.pop_front());
            m_press = 0; m_rel = 0;
            all_diff = (hist.size() == S + 1);
            foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
            if (all_diff) begin
                m_level = !m_level;
                if (m_level) m_press = 1; else m_rel = 1;
            end
            if (bus_if.clr_count) m_count = m_press ? 8'd1 : 8'd0;
            else if (m_press)     m_count = m_count + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_level",   32'(bus_if.btn_level),     32'(m_level));
            check("model_press",   32'(bus_if.press_pulse),   32'(m_press));
            check("model_release", 32'(bus_if.release_pulse), 32'(m_rel));
            check("model_count",   32'(bus_if.press_count),   32'(m_count));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_once();
        bus_if.btn_raw = 1'b1;
        cyc(12);
        bus_if.btn_raw = 1'b0;
        cyc(12);
    endtask

    initial begin
        bit seen;
        bit prev_press, prev_rel;
        int pulses;
        int cycles;
        int w;

        rst_n = 1'b0;
        bus_if.btn_raw   = 1'b0;
        bus_if.clr_count = 1'b0;
        cyc(3);
        check("rst_level",   32'(bus_if.btn_level),     0);
        check("rst_press",   32'(bus_if.press_pulse),   0);
        check("rst_release", 32'(bus_if.release_pulse), 0);
        check("rst_count",   32'(bus_if.press_count),   0);
        rst_n = 1'b1;
        model_on = 1'b1;
        cyc(4);

        // Bounce: 5 high / 3 low, four times, then low
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_if.btn_raw = 1'b1;
            repeat (5) begin
                cyc(1);
                seen |= bus_if.btn_level | bus_if.press_pulse | bus_if.release_pulse;
            end
            bus_if.btn_raw = 1'b0;
            repeat (3) begin
                cyc(1);
                seen |= bus_if.btn_level | bus_if.press_pulse | bus_if.release_pulse;
            end
        end
        repeat (12) begin
            cyc(1);
            seen |= bus_if.btn_level | bus_if.press_pulse | bus_if.release_pulse;
        end
        check("bounce_activity", 32'(seen), 0);
        check("bounce_count", 32'(bus_if.press_count), 0);

        // Clean press: accepted after edge E0+10
        bus_if.btn_raw = 1'b1;
        cyc(1);
        cyc(9);
        check("press_e9_level", 32'(bus_if.btn_level), 0);
        cyc(1);
        check("press_e10_level", 32'(bus_if.btn_level), 1);
        check("press_e10_pulse", 32'(bus_if.press_pulse), 1);
        check("press_e10_count", 32'(bus_if.press_count), 1);
        cyc(1);
        check("press_e11_pulse", 32'(bus_if.press_pulse), 0);

        // Release
        cyc(5);
        bus_if.btn_raw = 1'b0;
        cyc(1);
        cyc(9);
        check("rel_e9_level", 32'(bus_if.btn_level), 1);
        cyc(1);
        check("rel_e10_level", 32'(bus_if.btn_level), 0);
        check("rel_e10_pulse", 32'(bus_if.release_pulse), 1);
        check("rel_e10_count", 32'(bus_if.press_count), 1);
        cyc(1);
        check("rel_e11_pulse", 32'(bus_if.release_pulse), 0);

        // Clear, then 256 presses wrap to zero
        bus_if.clr_count = 1'b1;
        cyc(1);
        bus_if.clr_count = 1'b0;
        check("clr_count", 32'(bus_if.press_count), 0);
        for (int k = 0; k < 256; k++) press_once();
        check("wrap_count", 32'(bus_if.press_count), 0);
        for (int k = 0; k < 3; k++) press_once();
        check("three_count", 32'(bus_if.press_count), 3);

        // Clear coincident with a press commit
        bus_if.btn_raw = 1'b1;
        cyc(1);
        cyc(9);
        bus_if.clr_count = 1'b1;
        cyc(1);
        bus_if.clr_count = 1'b0;
        check("clr_commit_pulse", 32'(bus_if.press_pulse), 1);
        check("clr_commit_count", 32'(bus_if.press_count), 1);
        cyc(4);
        bus_if.btn_raw = 1'b0;
        cyc(14);

        // Reset at edge 5 of a press
        bus_if.btn_raw = 1'b1;
        cyc(1);
        cyc(5);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(bus_if.btn_level), 0);
        check("midrst_count", 32'(bus_if.press_count), 0);
        check("midrst_press", 32'(bus_if.press_pulse), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        cyc(9);
        check("postrst_e9_level", 32'(bus_if.btn_level), 0);
        cyc(1);
        check("postrst_e10_level", 32'(bus_if.btn_level), 1);
        check("postrst_e10_count", 32'(bus_if.press_count), 1);

        // Random bounce widths 1..12
        pulses = 0;
        cycles = 0;
        prev_press = bus_if.press_pulse;
        prev_rel   = bus_if.release_pulse;
        pulses = 0;
        while (cycles < 3000) begin
            w = $urandom_range(1, 12);
            bus_if.btn_raw = ~bus_if.btn_raw;
            repeat (w) begin
                cyc(1);
                cycles++;
                check("rnd_exclusive", 32'(bus_if.press_pulse & bus_if.release_pulse), 0);
                check("rnd_press_1cyc", 32'(bus_if.press_pulse & prev_press), 0);
                check("rnd_rel_1cyc", 32'(bus_if.release_pulse & prev_rel), 0);
                prev_press = bus_if.press_pulse;
                prev_rel   = bus_if.release_pulse;
                if (bus_if.press_pulse) pulses++;
            end
        end
        check("rnd_count_vs_strobes", 32'(bus_if.press_count), 32'((1 + pulses) % 256));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
